// File: rtl/univ_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared types for the universal shift register: the 3-bit command encoding
// and the two-state controller encoding. Imported by univ_shift_reg and
// usr_step.
// ---------------------------------------------------------------------------
package usr_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD = 3'd0,
      MODE_LOAD = 3'd1,
      MODE_SHL  = 3'd2,
      MODE_SHR  = 3'd3,
      MODE_ROTL = 3'd4,
      MODE_ROTR = 3'd5,
      MODE_ASHR = 3'd6,
      MODE_RSVD = 3'd7
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage : usr_pkg

// File: rtl/univ_shift_reg_step.sv
// ---------------------------------------------------------------------------
// usr_step
// Purely combinational single-step shifter. Given the current register value
// and a latched command, produces the value after one shift/rotate step.
// The arithmetic-right step exists only when USR_ARITH_SHIFT_EN is defined.
//
// Ports:
//   po    in  WIDTH   current register value
//   mode  in  mode_e  command being executed
//   si_l  in  1       serial bit entering the MSB on SHR
//   si_r  in  1       serial bit entering the LSB on SHL
//   nxt   out WIDTH   register value after one step
// ---------------------------------------------------------------------------
module usr_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] po,
   input  mode_e            mode,
   input  logic             si_l,
   input  logic             si_r,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      // NOTE: default assignment first so every path drives nxt; no latch.
      nxt = po;
      unique case (mode)
         MODE_SHL:  nxt = {po[WIDTH-2:0], si_r};
         MODE_SHR:  nxt = {si_l, po[WIDTH-1:1]};
         MODE_ROTL: nxt = {po[WIDTH-2:0], po[WIDTH-1]};
         MODE_ROTR: nxt = {po[0], po[WIDTH-1:1]};
`ifdef USR_ARITH_SHIFT_EN
         MODE_ASHR: nxt = {po[WIDTH-1], po[WIDTH-1:1]};
`endif
         default:   nxt = po;
      endcase
   end

endmodule : usr_step

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// Parametrised universal shift register with a start/busy/done command
// handshake. Supports HOLD, parallel LOAD, logical shifts and rotates in both
// directions, each repeated cnt times, one bit per clock.
// Optional feature macro: USR_ARITH_SHIFT_EN (enables mode 6, arithmetic
// right shift; without it mode 6 is reported as illegal like mode 7).
//
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      asynchronous reset, active-low
//   start  in  1      command strobe, sampled only while idle
//   mode   in  3      command code (see usr_pkg::mode_e)
//   cnt    in  CW     number of single-bit steps for shift/rotate commands
//   pi     in  WIDTH  parallel input for LOAD
//   si_l   in  1      serial input entering the MSB on SHR
//   si_r   in  1      serial input entering the LSB on SHL
//   po     out WIDTH  parallel output (register)
//   so_l   out 1      po MSB
//   so_r   out 1      po LSB
//   busy   out 1      multi-cycle command in progress
//   done   out 1      one-cycle completion pulse
//   err    out 1      qualifies done: illegal mode
// ---------------------------------------------------------------------------
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter int               CW      = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CW-1:0]    cnt,
   input  logic [WIDTH-1:0] pi,
   input  logic             si_l,
   input  logic             si_r,
   output logic [WIDTH-1:0] po,
   output logic             so_l,
   output logic             so_r,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_e           state;
   mode_e            mode_q;
   logic [CW-1:0]    rem;
   logic [WIDTH-1:0] step_val;
   mode_e            mode_in;

   assign mode_in = mode_e'(mode);
   assign so_l    = po[WIDTH-1];
   assign so_r    = po[0];

   // True for commands that run through the SHIFT state.
   function automatic logic is_shift_mode(input mode_e m);
      case (m)
         MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR: return 1'b1;
`ifdef USR_ARITH_SHIFT_EN
         MODE_ASHR:                                return 1'b1;
`endif
         default:                                  return 1'b0;
      endcase
   endfunction

   // Serial inputs reach the stepper live, so a stream can be fed one bit
   // per step edge.
   usr_step #(.WIDTH(WIDTH)) u_step (
      .po   (po),
      .mode (mode_q),
      .si_l (si_l),
      .si_r (si_r),
      .nxt  (step_val)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         mode_q <= MODE_HOLD;
         rem    <= '0;
         po     <= RST_VAL;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         // done/err are pulses: cleared every edge unless set below.
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  if (mode_in == MODE_HOLD) begin
                     done <= 1'b1;
                  end else if (mode_in == MODE_LOAD) begin
                     po   <= pi;
                     done <= 1'b1;
                  end else if (is_shift_mode(mode_in)) begin
                     if (cnt == '0) begin
                        done <= 1'b1;
                     end else begin
                        mode_q <= mode_in;
                        rem    <= cnt;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
                     end
                  end else begin
                     done <= 1'b1;
                     err  <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               // Inputs are ignored here; the last step also ends the command.
               po  <= step_val;
               rem <= rem - 1'b1;
               if (rem == CW'(1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed bench for univ_shift_reg (WIDTH=4, RST_VAL=0). Stimulus pushes the
// expected {po, err} of each command into a scoreboard queue; a monitor pops
// and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

   localparam int W  = 4;
   localparam int CW = 3;

   typedef struct packed {
      logic [W-1:0] po;
      logic         err;
   } resp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [2:0]    mode;
   logic [CW-1:0] cnt;
   logic [W-1:0]  pi;
   logic          si_l;
   logic          si_r;
   logic [W-1:0]  po;
   logic          so_l;
   logic          so_r;
   logic          busy;
   logic          done;
   logic          err;

   int    checks   = 0;
   int    failures = 0;
   resp_t sb[$];

   univ_shift_reg #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .cnt   (cnt),
      .pi    (pi),
      .si_l  (si_l),
      .si_r  (si_r),
      .po    (po),
      .so_l  (so_l),
      .so_r  (so_r),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   // Negedge at 5 ns, posedges at 10, 20, ...
   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: compares each done pulse against the oldest entry.
   always @(negedge clk) begin
      if (rst) begin
         if (done) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_done: po=%b err=%b with empty scoreboard at %0t", po, err, $time);
            end else begin
               resp_t e;
               e = sb.pop_front();
               if (po !== e.po || err !== e.err || busy !== 1'b0) begin
                  failures++;
                  $display("FAIL sb_resp: got po=%b err=%b busy=%b expected po=%b err=%b busy=0 at %0t",
                           po, err, busy, e.po, e.err, $time);
               end
            end
         end else begin
            checks++;
            if (err !== 1'b0) begin
               failures++;
               $display("FAIL err_without_done: err=%b at %0t", err, $time);
            end
         end
      end
   end

   // Issue one command at a negedge; return at the negedge where busy is low
   // again (the done cycle).
   task automatic run_cmd(input logic [2:0] m, input logic [CW-1:0] c, input logic [W-1:0] p,
                          input logic [W-1:0] exp_po, input logic exp_err, input int exp_busy);
      int n;
      start = 1'b1;
      mode  = m;
      cnt   = c;
      pi    = p;
      sb.push_back('{po: exp_po, err: exp_err});
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", n, exp_busy);
      check("done_seen", done, 1'b1);
   endtask

   initial begin
      int n;
      rst   = 1'b0;
      start = 1'b0;
      mode  = 3'd0;
      cnt   = '0;
      pi    = '0;
      si_l  = 1'b0;
      si_r  = 1'b0;

      // Reset state.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_po", po, 4'b0000);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      @(negedge clk);

      // LOAD 1010, done lasts exactly one cycle.
      run_cmd(3'd1, 3'd0, 4'b1010, 4'b1010, 1'b0, 0);
      @(negedge clk);
      check("load_done_one_cycle", done, 1'b0);
      check("load_po", po, 4'b1010);
      run_cmd(3'd1, 3'd0, 4'b1111, 4'b1111, 1'b0, 0);

      // ROTL cnt=3 from 1010, each step checked.
      run_cmd(3'd1, 3'd0, 4'b1010, 4'b1010, 1'b0, 0);
      start = 1'b1; mode = 3'd4; cnt = 3'd3;
      sb.push_back('{po: 4'b0101, err: 1'b0});
      @(negedge clk); start = 1'b0;
      check("rotl_e0_po", po, 4'b1010);
      check("rotl_e0_busy", busy, 1'b1);
      check("rotl_e0_so", {so_l, so_r}, 2'b10);
      @(negedge clk);
      check("rotl_e1_po", po, 4'b0101);
      check("rotl_e1_busy", busy, 1'b1);
      @(negedge clk);
      check("rotl_e2_po", po, 4'b1010);
      check("rotl_e2_busy", busy, 1'b1);
      @(negedge clk);
      check("rotl_e3_po", po, 4'b0101);
      check("rotl_e3_busy", busy, 1'b0);
      check("rotl_e3_done", done, 1'b1);

      // SHR cnt=2 with si_l=1: 0101 -> 1010 -> 1101; then SHL cnt=1, si_r=0.
      si_l = 1'b1;
      run_cmd(3'd3, 3'd2, 4'b0000, 4'b1101, 1'b0, 2);
      si_r = 1'b0;
      run_cmd(3'd2, 3'd1, 4'b0000, 4'b1010, 1'b0, 1);

      // SHL cnt=5 (> WIDTH) with si_r=1 while LOAD 0000 is held on start,
      // including at the done edge: the load must be ignored.
      si_r  = 1'b1;
      start = 1'b1; mode = 3'd2; cnt = 3'd5;
      sb.push_back('{po: 4'b1111, err: 1'b0});
      @(negedge clk);
      mode = 3'd1; pi = 4'b0000;
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      check("shl5_busy_cycles", n, 5);
      check("shl5_po", po, 4'b1111);
      @(negedge clk);
      check("shl5_load_ignored_po", po, 4'b1111);
      check("shl5_no_second_done", done, 1'b0);

      // Mode 6 from 1000.
      run_cmd(3'd1, 3'd0, 4'b1000, 4'b1000, 1'b0, 0);
`ifdef USR_ARITH_SHIFT_EN
      run_cmd(3'd6, 3'd2, 4'b0000, 4'b1110, 1'b0, 2);
`else
      run_cmd(3'd6, 3'd2, 4'b0000, 4'b1000, 1'b1, 0);
`endif

      // Zero-count rotate, reserved mode and HOLD: no busy, po unchanged.
      run_cmd(3'd1, 3'd0, 4'b0110, 4'b0110, 1'b0, 0);
      run_cmd(3'd5, 3'd0, 4'b1001, 4'b0110, 1'b0, 0);
      run_cmd(3'd7, 3'd3, 4'b1001, 4'b0110, 1'b1, 0);
      run_cmd(3'd0, 3'd2, 4'b1001, 4'b0110, 1'b0, 0);

      // Reset mid-command aborts it with no done pulse.
      start = 1'b1; mode = 3'd4; cnt = 3'd7;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      check("abort_busy_before", busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("abort_po", po, 4'b0000);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_err", err, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      check("abort_idle_busy", busy, 1'b0);
      check("abort_idle_po", po, 4'b0000);
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule : tb_univ_shift_reg
